req_queue5_2: RTL and testbench
===============================

# req_queue5_2

Per-requester request buffer that sits around the 5-requester, 2-grant rotating arbiter: upstream, it queues payloads from five requesters and drives the arbiter's request vector and `valid`; downstream, it consumes the arbiter's registered grant vector and pops granted payloads onto two output lanes. It keeps the arbiter from granting the same entry twice, because the grant arrives one cycle after the request.

## Interface
- `DW`, 8, payload width in bits
- `DEPTH`, 4, entries per requester queue (power of two, ≥2)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  asynchronous, active-high reset
- `push`  in  5  per-requester push strobe
- `push_data`  in  5*DW  payload for requester i at bits [i*DW +: DW]
- `full`  out  5  queue i holds DEPTH entries
- `req_out`  out  5  request vector to the arbiter's `req_in`
- `req_valid`  out  1  to the arbiter's `valid`; equals |`req_out`
- `grant_in`  in  5  arbiter's registered `grant_out`
- `out0_vld`, `out1_vld`  out  1  lane valid
- `out0_id`, `out1_id`  out  3  requester index 0..4
- `out0_data`, `out1_data`  out  DW  popped payload
- `overflow`  out  1  sticky: a push to a full queue that is not popping in the same cycle
- `err_grant`  out  1  sticky: grant to an empty queue, or more than 2 grant bits set

## Operation
- Five independent FIFOs, each DEPTH deep, with wr/rd pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
- `pop[i]` = `grant_in[i]` & (count[i] != 0).
- Push:
  - Push to a non-full queue writes the tail.
  - Push to a full queue is accepted only if `pop[i]` is also set (count unchanged). Otherwise it is dropped and sets `overflow`.
- Request generation is combinational:
  - `req_out[i]` = (count[i] − `pop[i]`) != 0.
  - An entry granted this cycle is therefore not requested again.
  - Same-cycle pushes are not counted.
- Lane assignment is registered:
  - Among the popped bits, the lowest index goes to lane 0 and the next-lowest to lane 1.
  - A single pop always uses lane 0.
  - Pops beyond two are discarded (head not advanced) and set `err_grant`.
- A grant bit on an empty queue is ignored and sets `err_grant`.
- Pointers wrap modulo DEPTH.

## Timing
- On reset, asynchronously:
  - all counts, pointers and lane outputs clear.
  - `full`=0, `req_out`=0, `req_valid`=0, `overflow`=0, `err_grant`=0.
- Push at cycle t: count updates at the end of t, and `req_out` rises in t+1.
- Arbiter round trip:
  - `req_out` in cycle r is seen by the arbiter, which registers the grant.
  - `grant_in` is high in r+1.
  - Pop and head advance occur at the end of r+1.
  - The lane output is valid in r+2.
- Back-to-back grants:
  - A queue with ≥2 entries keeps `req_out` high through the grant cycle.
  - It can therefore be granted every cycle.
- Push and pop in the same cycle: count unchanged; the lane carries the old head.
- Reset asserted mid-operation: in-flight entries and lanes are lost, and the lanes go invalid immediately.
- Sticky flags clear only on `rst`.

## Structure
- Package `arb5_pkg`:
  - `NREQ`=5 and `NGNT`=2.
  - Requester-index typedef (3 bits).
  - Lane struct {vld, id, data}.
- Sub-module `req_fifo`: one parameterised FIFO exposing count, head data, push, pop, full. It is instantiated five times.
- The top level holds the request logic, the two-lowest-bit lane select and the error flags.

## Test plan
- Reset release, then push requester 2 with 0xA5 → `req_out`=00100 next cycle. Drive `grant_in`=00100 → `out0_vld`=1, `out0_id`=2, `out0_data`=0xA5 one cycle later. `req_out` drops in the grant cycle.
- Push requesters 1 and 3 with 0x11 and 0x33, then grant 01010 → lane0 = {1, 0x11}, lane1 = {3, 0x33}.
- Push requester 0 five times with 0x00–0x04 (DEPTH=4) → `full[0]`=1 after the 4th push. The 5th push sets `overflow`. Four grants then return 0x00–0x03 in order, and the pointers wrap correctly on a refill.
- Queue 4 full, with `push[4]` and `grant_in[4]` in the same cycle → count stays 4, `overflow` stays 0, and the lane returns the old head.
- `grant_in`=00001 with queue 0 empty → `err_grant`=1 and no lane valid. Separately, `grant_in`=00111 with all queues non-empty → `err_grant`=1, lanes carry ids 0 and 1, and queue 2 is untouched.
- Assert `rst` while lanes are valid and queues are half-full → all outputs are 0 immediately, and `req_out`=0 after release.

Source files
------------

// File: rtl/req_queue5_2_pkg.sv
// Shared types for the 5-requester / 2-grant request buffer.
// Lane payload field is sized for the widest supported DW; narrower payloads are zero-extended.
package arb5_pkg;
    localparam int NREQ        = 5;
    localparam int NGNT        = 2;
    localparam int LANE_DW_MAX = 32;

    typedef logic [2:0] req_idx_t;

    typedef struct packed {
        logic                   vld;
        req_idx_t               id;
        logic [LANE_DW_MAX-1:0] data;
    } lane_t;
endpackage

// File: rtl/req_queue5_2_if.sv
// Push / request / grant / lane bundle between requesters, arbiter and the request buffer.
// master = environment side, slave = buffer side.
interface req_queue5_2_if #(parameter int DW = 8);
    logic [arb5_pkg::NREQ-1:0]    push;
    logic [arb5_pkg::NREQ*DW-1:0] push_data;
    logic [arb5_pkg::NREQ-1:0]    full;
    logic [arb5_pkg::NREQ-1:0]    req_out;
    logic                         req_valid;
    logic [arb5_pkg::NREQ-1:0]    grant_in;
    logic                         out0_vld;
    logic [2:0]                   out0_id;
    logic [DW-1:0]                out0_data;
    logic                         out1_vld;
    logic [2:0]                   out1_id;
    logic [DW-1:0]                out1_data;
    logic                         overflow;
    logic                         err_grant;

    modport master (
        output push, push_data, grant_in,
        input  full, req_out, req_valid,
        input  out0_vld, out0_id, out0_data, out1_vld, out1_id, out1_data,
        input  overflow, err_grant
    );

    modport slave (
        input  push, push_data, grant_in,
        output full, req_out, req_valid,
        output out0_vld, out0_id, out0_data, out1_vld, out1_id, out1_data,
        output overflow, err_grant
    );
endinterface

// File: rtl/req_queue5_2_fifo.sv
// Per-requester FIFO: head is combinational, push/pop take effect at the clock edge.
// A push while full is accepted only together with a pop; otherwise it is dropped.
module req_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DW-1:0]            wdata,
    output logic [DW-1:0]            head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   cnt_q;
    logic          wr;
    logic          rd;

    assign full  = (cnt_q == (AW+1)'(DEPTH));
    assign rd    = pop && (cnt_q != '0);
    assign wr    = push && (!full || rd);
    assign head  = mem[rptr];
    assign count = cnt_q;

    // When full, wptr == rptr: the write lands in the slot being read, but
    // the reader samples the old value before the edge.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            case ({wr, rd})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end
endmodule

// File: rtl/req_queue5_2.sv
// Request buffer around the 5x2 arbiter: queues payloads, raises requests net of in-flight grants,
// pops granted heads onto two registered lanes (one cycle after grant); DW must not exceed LANE_DW_MAX.
module req_queue5_2
    import arb5_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    req_queue5_2_if.slave  bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   cnt  [NREQ];
    logic [DW-1:0]   head [NREQ];
    logic [NREQ-1:0] fifo_full;
    logic [NREQ-1:0] nonempty;
    logic [NREQ-1:0] pop_ok;
    logic [NREQ-1:0] pop;
    logic [NREQ-1:0] req;

    logic            got0;
    logic            got1;
    req_idx_t        id0;
    req_idx_t        id1;
    logic [DW-1:0]   d0;
    logic [DW-1:0]   d1;

    lane_t           lane0_nxt;
    lane_t           lane1_nxt;
    lane_t           lane0_q;
    lane_t           lane1_q;
    logic            ovf_evt;
    logic            err_evt;
    logic            overflow_q;
    logic            err_q;

    for (genvar g = 0; g < NREQ; g++) begin : g_q
        req_fifo #(
            .DW    (DW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (bus.push[g]),
            .pop   (pop[g]),
            .wdata (bus.push_data[g*DW +: DW]),
            .head  (head[g]),
            .count (cnt[g]),
            .full  (fifo_full[g])
        );
    end

    always_comb begin
        nonempty = '0;
        for (int i = 0; i < NREQ; i++) begin
            nonempty[i] = (cnt[i] != '0);
        end
    end

    assign pop_ok = bus.grant_in & nonempty;

    // Two lowest granted non-empty queues win the lanes; any others keep their head.
    always_comb begin
        got0 = 1'b0;
        got1 = 1'b0;
        id0  = '0;
        id1  = '0;
        d0   = '0;
        d1   = '0;
        pop  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pop_ok[i]) begin
                if (!got0) begin
                    got0   = 1'b1;
                    id0    = req_idx_t'(i);
                    d0     = head[i];
                    pop[i] = 1'b1;
                end else if (!got1) begin
                    got1   = 1'b1;
                    id1    = req_idx_t'(i);
                    d1     = head[i];
                    pop[i] = 1'b1;
                end
            end
        end
    end

    // Entry already granted this cycle is not requested again; same-cycle pushes are ignored.
    always_comb begin
        req = '0;
        for (int i = 0; i < NREQ; i++) begin
            req[i] = pop[i] ? (cnt[i] > CW'(1)) : nonempty[i];
        end
    end

    always_comb begin
        lane0_nxt      = '0;
        lane1_nxt      = '0;
        lane0_nxt.vld  = got0;
        lane0_nxt.id   = id0;
        lane0_nxt.data = LANE_DW_MAX'(d0);
        lane1_nxt.vld  = got1;
        lane1_nxt.id   = id1;
        lane1_nxt.data = LANE_DW_MAX'(d1);
    end

    assign ovf_evt = |(bus.push & fifo_full & ~pop);
    assign err_evt = (|(bus.grant_in & ~nonempty))
                   || ($countones(bus.grant_in) > NGNT)
                   || (|(pop_ok & ~pop));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane0_q    <= '0;
            lane1_q    <= '0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            lane0_q    <= lane0_nxt;
            lane1_q    <= lane1_nxt;
            overflow_q <= overflow_q | ovf_evt;
            err_q      <= err_q | err_evt;
        end
    end

    assign bus.full      = fifo_full;
    assign bus.req_out   = req;
    assign bus.req_valid = |req;
    assign bus.out0_vld  = lane0_q.vld;
    assign bus.out0_id   = lane0_q.id;
    assign bus.out0_data = lane0_q.data[DW-1:0];
    assign bus.out1_vld  = lane1_q.vld;
    assign bus.out1_id   = lane1_q.id;
    assign bus.out1_data = lane1_q.data[DW-1:0];
    assign bus.overflow  = overflow_q;
    assign bus.err_grant = err_q;

    // Lane payload field is wider than DW; the upper bits are always zero.
    logic lane_pad_unused;
    assign lane_pad_unused = ^{lane0_q.data, lane1_q.data};
endmodule

// File: tb/tb_req_queue5_2.sv
// Directed bench for req_queue5_2: vector table for the basic flows, hand sequences for the corner cases.
module tb_req_queue5_2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    logic [4:0] req_s;
    logic       vld_s;
    logic [4:0] full_s;

    req_queue5_2_if #(.DW(8)) bus ();

    req_queue5_2 #(.DW(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  push;
        logic [39:0] data;
        logic [4:0]  grant;
        logic [4:0]  req;
        logic [4:0]  full;
        logic        v0;
        logic [2:0]  id0;
        logic [7:0]  d0;
        logic        v1;
        logic [2:0]  id1;
        logic [7:0]  d1;
        logic        ovf;
        logic        err;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one cycle starting just after a rising edge; sample combinational outputs
    // at the falling edge, then return just after the next rising edge.
    task automatic cyc(input logic [4:0] p, input logic [39:0] d, input logic [4:0] g);
        bus.push      = p;
        bus.push_data = d;
        bus.grant_in  = g;
        @(negedge clk);
        req_s  = bus.req_out;
        vld_s  = bus.req_valid;
        full_s = bus.full;
        @(posedge clk);
        #1;
        bus.push      = '0;
        bus.push_data = '0;
        bus.grant_in  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lane0(input string name, input logic [2:0] id, input logic [7:0] d);
        chk({name, ".vld0"}, bus.out0_vld, 1'b1);
        chk({name, ".id0"}, bus.out0_id, id);
        chk({name, ".data0"}, bus.out0_data, d);
    endtask

    initial begin
        bus.push      = '0;
        bus.push_data = '0;
        bus.grant_in  = '0;

        tbl[0] = '{5'b00100, 40'h00_00_A5_00_00, 5'b00000, 5'b00000, 5'b00000,
                   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        tbl[1] = '{5'b00000, 40'h0, 5'b00000, 5'b00100, 5'b00000,
                   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        tbl[2] = '{5'b00000, 40'h0, 5'b00100, 5'b00000, 5'b00000,
                   1'b1, 3'd2, 8'hA5, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        tbl[3] = '{5'b01010, 40'h00_33_00_11_00, 5'b00000, 5'b00000, 5'b00000,
                   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{5'b00000, 40'h0, 5'b01010, 5'b00000, 5'b00000,
                   1'b1, 3'd1, 8'h11, 1'b1, 3'd3, 8'h33, 1'b0, 1'b0};
        tbl[5] = '{5'b00000, 40'h0, 5'b00001, 5'b00000, 5'b00000,
                   1'b0, 3'd0, 8'h00, 1'b0, 3'd0, 8'h00, 1'b0, 1'b1};

        // Reset state
        #12;
        chk("rst.req_out", bus.req_out, 5'b0);
        chk("rst.req_valid", bus.req_valid, 1'b0);
        chk("rst.full", bus.full, 5'b0);
        chk("rst.out0_vld", bus.out0_vld, 1'b0);
        chk("rst.out1_vld", bus.out1_vld, 1'b0);
        chk("rst.overflow", bus.overflow, 1'b0);
        chk("rst.err_grant", bus.err_grant, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int v = 0; v < 6; v++) begin
            cyc(tbl[v].push, tbl[v].data, tbl[v].grant);
            chk($sformatf("v%0d.req_out", v), req_s, tbl[v].req);
            chk($sformatf("v%0d.req_valid", v), vld_s, |tbl[v].req);
            chk($sformatf("v%0d.full", v), full_s, tbl[v].full);
            chk($sformatf("v%0d.out0_vld", v), bus.out0_vld, tbl[v].v0);
            chk($sformatf("v%0d.out1_vld", v), bus.out1_vld, tbl[v].v1);
            if (tbl[v].v0) begin
                chk($sformatf("v%0d.out0_id", v), bus.out0_id, tbl[v].id0);
                chk($sformatf("v%0d.out0_data", v), bus.out0_data, tbl[v].d0);
            end
            if (tbl[v].v1) begin
                chk($sformatf("v%0d.out1_id", v), bus.out1_id, tbl[v].id1);
                chk($sformatf("v%0d.out1_data", v), bus.out1_data, tbl[v].d1);
            end
            chk($sformatf("v%0d.overflow", v), bus.overflow, tbl[v].ovf);
            chk($sformatf("v%0d.err_grant", v), bus.err_grant, tbl[v].err);
        end

        // Fill queue 0, overflow on the fifth push, drain in order, refill across the wrap
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(5'b00001, 40'(k), 5'b0);
        end
        cyc(5'b00001, 40'h04, 5'b0);
        chk("fill.full0", full_s, 5'b00001);
        chk("fill.req", req_s, 5'b00001);
        chk("fill.overflow", bus.overflow, 1'b1);
        for (int k = 0; k < 4; k++) begin
            cyc(5'b0, 40'h0, 5'b00001);
            chk($sformatf("drain%0d.req", k), req_s[0], (4 - k) > 1);
            chk_lane0($sformatf("drain%0d", k), 3'd0, 8'(k));
        end
        cyc(5'b00001, 40'h10, 5'b0);
        cyc(5'b00001, 40'h11, 5'b0);
        cyc(5'b0, 40'h0, 5'b00001);
        chk_lane0("wrap0", 3'd0, 8'h10);
        cyc(5'b0, 40'h0, 5'b00001);
        chk_lane0("wrap1", 3'd0, 8'h11);
        chk("wrap.err_grant", bus.err_grant, 1'b0);

        // Queue 4 full with push and grant in the same cycle
        do_reset();
        for (int k = 0; k < 4; k++) begin
            cyc(5'b10000, {8'(8'h40 + k), 32'h0}, 5'b0);
        end
        cyc(5'b10000, {8'h44, 32'h0}, 5'b10000);
        chk("pp.full_during", full_s, 5'b10000);
        chk_lane0("pp", 3'd4, 8'h40);
        chk("pp.overflow", bus.overflow, 1'b0);
        cyc(5'b0, 40'h0, 5'b0);
        chk("pp.full_after", full_s, 5'b10000);
        for (int k = 1; k < 5; k++) begin
            cyc(5'b0, 40'h0, 5'b10000);
            chk_lane0($sformatf("pp_drain%0d", k), 3'd4, 8'(8'h40 + k));
        end

        // Three grants: two lowest pop, queue 2 keeps its entry
        do_reset();
        cyc(5'b00111, 40'h00_00_A2_A1_A0, 5'b0);
        cyc(5'b0, 40'h0, 5'b00111);
        chk_lane0("g3", 3'd0, 8'hA0);
        chk("g3.vld1", bus.out1_vld, 1'b1);
        chk("g3.id1", bus.out1_id, 3'd1);
        chk("g3.data1", bus.out1_data, 8'hA1);
        chk("g3.err_grant", bus.err_grant, 1'b1);
        cyc(5'b0, 40'h0, 5'b0);
        chk("g3.req_after", req_s, 5'b00100);
        cyc(5'b0, 40'h0, 5'b00100);
        chk_lane0("g3.q2", 3'd2, 8'hA2);

        // Reset with lanes valid and queues half full
        do_reset();
        cyc(5'b00011, 40'h00_00_00_02_01, 5'b0);
        cyc(5'b00011, 40'h00_00_00_04_03, 5'b0);
        cyc(5'b0, 40'h0, 5'b00011);
        chk("mid.vld0", bus.out0_vld, 1'b1);
        chk("mid.vld1", bus.out1_vld, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid.rst_vld0", bus.out0_vld, 1'b0);
        chk("mid.rst_vld1", bus.out1_vld, 1'b0);
        chk("mid.rst_data0", bus.out0_data, 8'h00);
        chk("mid.rst_req", bus.req_out, 5'b0);
        chk("mid.rst_req_valid", bus.req_valid, 1'b0);
        chk("mid.rst_full", bus.full, 5'b0);
        chk("mid.rst_flags", {bus.overflow, bus.err_grant}, 2'b00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        cyc(5'b0, 40'h0, 5'b0);
        chk("mid.req_after", req_s, 5'b0);
        chk("mid.vld_after", bus.out0_vld, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
